// File: rtl/i2s_word_packer_pkg.sv
// Shared constants, the sample record and a saturating-increment helper
// for the I2S receive word packer.
package i2s_pkg;

    localparam int SLOT_W     = 4;   // TDM slot index width
    localparam int MAX_BYTES  = 4;   // bytes in a full sample
    localparam int SAMPLE_W   = 32;  // sample width
    localparam int CNT_W      = 16;  // status counter width
    localparam int BCNT_W     = $clog2(MAX_BYTES);

    // One buffered sample: data, slot tag and frame-last flag
    typedef struct packed {
        logic [SAMPLE_W-1:0] data;
        logic [SLOT_W-1:0]   user;
        logic                last;
    } sample_t;

    localparam int SAMPLE_T_W = $bits(sample_t);

    // Increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/i2s_word_packer_if.sv
// Byte-stream input and sample-stream output of the word packer.
// 'master' is the packer side, 'slave' is the PHY/consumer side.
interface i2s_word_packer_if;
    import i2s_pkg::*;

    logic                s_axis_tvalid;
    logic [7:0]          s_axis_tdata;
    logic                s_axis_tlast;

    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic [SAMPLE_W-1:0] m_axis_tdata;
    logic [SLOT_W-1:0]   m_axis_tuser;
    logic                m_axis_tlast;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );

endinterface

// File: rtl/i2s_word_packer_fifo.sv
// i2s_word_fifo: first-word-fall-through sample FIFO. The head entry lives
// in a registered output stage that counts toward DEPTH, so total capacity
// is exactly DEPTH words and a write into an empty FIFO shows up on the
// output one cycle after the write edge.
module i2s_word_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    output logic         full_o,
    input  logic         rd_ready_i,
    output logic         empty_o,
    output logic [W-1:0] rd_data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr_q, rptr_q, mem_cnt;
    logic         out_vld_q;
    logic [W-1:0] out_q;
    logic         pop, load, wr;

    assign mem_cnt = wptr_q - rptr_q;
    assign full_o  = (mem_cnt + (AW+1)'(out_vld_q)) == FULL_CNT;
    assign empty_o = !out_vld_q;
    assign pop     = out_vld_q && rd_ready_i;
    // A full FIFO still takes a write when the head leaves the same cycle
    assign wr      = wr_en_i && (!full_o || pop);
    // Refill the output stage whenever it is free or being consumed
    assign load    = (mem_cnt != '0) && (!out_vld_q || pop);
    assign rd_data_o = out_q;

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (wr) mem[wptr_q[AW-1:0]] <= wr_data_i;
    end

    // Pointers and the registered head entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            if (wr) wptr_q <= wptr_q + (AW+1)'(1);
            if (load) begin
                rptr_q    <= rptr_q + (AW+1)'(1);
                out_q     <= mem[rptr_q[AW-1:0]];
                out_vld_q <= 1'b1;
            end else if (pop) begin
                out_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2s_word_packer.sv
// i2s_word_packer: packs the PHY's MSB-first byte stream into 32-bit
// samples tagged with TDM slot and frame-last, buffered in a FIFO and
// presented as an AXI-Stream master.
// Build option: I2S_WORD_PACKER_SIGN_EXT_EN selects right-justified,
// sign-extended samples instead of MSB-justified zero-padded ones.
module i2s_word_packer
    import i2s_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              bclk,
    input  logic              rst_n,
    i2s_word_packer_if.master axis,
    input  logic [4:0]        i_tdm_num,
    input  logic [5:0]        i_valid_word_width,
    output logic [CNT_W-1:0]  o_overflow_count,
    output logic [CNT_W-1:0]  o_resync_count
);
    logic [1:0]          rst_sync_q;
    logic                rst_int_n;
    logic [2:0]          nbytes;
    logic [4:0]          tdm;
    logic [BCNT_W-1:0]   bc_cur, byte_cnt_q, byte_cnt_d;
    logic [SLOT_W-1:0]   sc_cur, slot_cnt_q, slot_cnt_d;
    logic [SAMPLE_W-1:0] acc_q, acc_d, word;
    sample_t             stg_q, stg_d, fifo_out;
    logic                stg_vld_q, stg_vld_d;
    logic [CNT_W-1:0]    ovf_q, ovf_d, rsy_q, rsy_d;
    logic                fifo_full, fifo_empty;

    // Async assert, bclk-synchronised release of the internal reset
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // Config decode and range-clamping of the counters against live config
    always_comb begin
        nbytes = i_valid_word_width[5:3];
        if (nbytes == 3'd0)      nbytes = 3'd1;
        else if (nbytes > 3'd4)  nbytes = 3'd4;
        tdm = i_tdm_num;
        if (tdm == 5'd0)         tdm = 5'd1;
        else if (tdm > 5'd16)    tdm = 5'd16;
        bc_cur = ({1'b0, byte_cnt_q} >= nbytes) ? '0 : byte_cnt_q;
        sc_cur = ({1'b0, slot_cnt_q} >= tdm)    ? '0 : slot_cnt_q;
    end

    // Byte accumulation, sample completion and tlast resync
    always_comb begin
        acc_d      = acc_q;
        byte_cnt_d = bc_cur;
        slot_cnt_d = sc_cur;
        stg_d      = stg_q;
        stg_vld_d  = 1'b0;
        rsy_d      = rsy_q;
        // First byte of a sample starts from zero so unused low bytes stay 0
        word = (bc_cur == '0) ? '0 : acc_q;
        word = word | ({axis.s_axis_tdata, 24'h0} >> {bc_cur, 3'b000});
        if (axis.s_axis_tvalid) begin
            acc_d = word;
            if ({1'b0, bc_cur} == nbytes - 3'd1) begin
                stg_vld_d  = 1'b1;
`ifdef I2S_WORD_PACKER_SIGN_EXT_EN
                stg_d.data = $signed(word) >>> (6'd32 - {nbytes, 3'b000});
`else
                stg_d.data = word;
`endif
                stg_d.user = sc_cur;
                stg_d.last = ({1'b0, sc_cur} == tdm - 5'd1);
                byte_cnt_d = '0;
                slot_cnt_d = stg_d.last ? '0 : sc_cur + SLOT_W'(1);
            end else begin
                byte_cnt_d = bc_cur + BCNT_W'(1);
            end
        end
        // tlast acts after the same-cycle byte; a leftover partial is dropped
        if (axis.s_axis_tlast) begin
            if (byte_cnt_d != '0) rsy_d = sat_inc(rsy_q);
            byte_cnt_d = '0;
            slot_cnt_d = '0;
        end
    end

    // Staged words that find the FIFO full (and not draining) are counted
    always_comb begin
        ovf_d = ovf_q;
        if (stg_vld_q && fifo_full && !(axis.m_axis_tvalid && axis.m_axis_tready))
            ovf_d = sat_inc(ovf_q);
    end

    // Packer state, staging register and status counters
    always_ff @(posedge bclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            acc_q      <= '0;
            byte_cnt_q <= '0;
            slot_cnt_q <= '0;
            stg_q      <= '0;
            stg_vld_q  <= 1'b0;
            ovf_q      <= '0;
            rsy_q      <= '0;
        end else begin
            acc_q      <= acc_d;
            byte_cnt_q <= byte_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            stg_q      <= stg_d;
            stg_vld_q  <= stg_vld_d;
            ovf_q      <= ovf_d;
            rsy_q      <= rsy_d;
        end
    end

    i2s_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (SAMPLE_T_W)
    ) u_fifo (
        .clk        (bclk),
        .rst_n      (rst_int_n),
        .wr_en_i    (stg_vld_q),
        .wr_data_i  (stg_q),
        .full_o     (fifo_full),
        .rd_ready_i (axis.m_axis_tready),
        .empty_o    (fifo_empty),
        .rd_data_o  (fifo_out)
    );

    assign axis.m_axis_tvalid = !fifo_empty;
    assign axis.m_axis_tdata  = fifo_out.data;
    assign axis.m_axis_tuser  = fifo_out.user;
    assign axis.m_axis_tlast  = fifo_out.last;
    assign o_overflow_count   = ovf_q;
    assign o_resync_count     = rsy_q;

endmodule

// File: tb/tb_i2s_word_packer.sv
// Self-checking bench for i2s_word_packer: directed scenarios plus random
// frames, compared against a byte-list reference model and a sample queue.
module tb_i2s_word_packer;

    logic        bclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  tdm_num = 5'd1;
    logic [5:0]  vww = 6'd32;
    logic [15:0] ovf_cnt, rsy_cnt;

    i2s_word_packer_if bus();

    i2s_word_packer #(.FIFO_DEPTH(8)) dut (
        .bclk               (bclk),
        .rst_n              (rst_n),
        .axis               (bus),
        .i_tdm_num          (tdm_num),
        .i_valid_word_width (vww),
        .o_overflow_count   (ovf_cnt),
        .o_resync_count     (rsy_cnt)
    );

    always #5 bclk = ~bclk;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;   // 0: tready low, 1: tready high, 2: random
    int n_out = 0;
    int base;

    // reference model state
    logic [7:0]  part[$];
    int          m_slot = 0;
    logic [36:0] exp_q[$];
    int          exp_ovf = 0;
    int          exp_rsy = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_nbytes();
        int n = int'(vww) / 8;
        if (n < 1) n = 1;
        if (n > 4) n = 4;
        return n;
    endfunction

    function automatic int m_tdm();
        int t = int'(tdm_num);
        if (t == 0) t = 1;
        if (t > 16) t = 16;
        return t;
    endfunction

    task automatic model(input logic v, input logic [7:0] b, input logic l);
        int n = m_nbytes();
        int t = m_tdm();
        longint val;
        logic [31:0] w;
        if (v) begin
            part.push_back(b);
            if (part.size() == n) begin
                val = 0;
                foreach (part[i]) val = val * 256 + longint'(part[i]);
`ifdef I2S_WORD_PACKER_SIGN_EXT_EN
                if (val >= (64'sd1 <<< (8*n-1))) val = val - (64'sd1 <<< (8*n));
                w = val[31:0];
`else
                w = 32'(val << (8*(4-n)));
`endif
                exp_q.push_back({w, 4'(m_slot), m_slot == t-1});
                m_slot = (m_slot + 1) % t;
                part.delete();
            end
        end
        if (l) begin
            if (part.size() != 0) exp_rsy++;
            part.delete();
            m_slot = 0;
        end
    endtask

    // drive one cycle of PHY input at a negedge, then advance to the next one
    task automatic drive(input logic v, input logic [7:0] b, input logic l);
        bus.s_axis_tvalid = v;
        bus.s_axis_tdata  = b;
        bus.s_axis_tlast  = l;
        model(v, b, l);
        @(negedge bclk);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge bclk);
            t++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge bclk);
    endtask

    // output monitor: picks tready, scores transfers, checks stall stability
    logic        stalled = 1'b0;
    logic [36:0] snap, got, e;
    initial begin
        forever begin
            @(negedge bclk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                got = {bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast};
                if (stalled) begin
                    chk("stall_vld", 64'(bus.m_axis_tvalid), 64'd1);
                    chk("stall_dat", 64'(got), 64'(snap));
                end
                case (rdy_mode)
                    0:       bus.m_axis_tready = 1'b0;
                    1:       bus.m_axis_tready = 1'b1;
                    default: bus.m_axis_tready = 1'($urandom_range(0, 1));
                endcase
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    n_out++;
                    if (exp_q.size() == 0) chk("extra_out", 64'd1, 64'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("sample", 64'(got), 64'(e));
                    end
                end
                stalled = bus.m_axis_tvalid && !bus.m_axis_tready;
                snap = got;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, n, t;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 8'h0;
        bus.s_axis_tlast  = 1'b0;
        bus.m_axis_tready = 1'b0;
        repeat (3) @(negedge bclk);
        chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("rst_tdata",  64'(bus.m_axis_tdata),  64'd0);
        chk("rst_tuser",  64'(bus.m_axis_tuser),  64'd0);
        chk("rst_tlast",  64'(bus.m_axis_tlast),  64'd0);
        chk("rst_ovf",    64'(ovf_cnt), 64'd0);
        chk("rst_rsy",    64'(rsy_cnt), 64'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge bclk);
        rdy_mode = 1;

        // two 24-bit slots, tlast on the 6th byte
        tdm_num = 5'd2; vww = 6'd24;
        drive(1, 8'h12, 0); drive(1, 8'h34, 0); drive(1, 8'h56, 0);
        drive(1, 8'hAB, 0); drive(1, 8'hCD, 0); drive(1, 8'hEF, 1);
        drive(0, 8'h00, 0);
        drain();
        chk("t1_rsy", 64'(rsy_cnt), 64'(exp_rsy));

        // 8 slots x 32 bit, 3 frames back to back; first-sample latency
        tdm_num = 5'd8; vww = 6'd32;
        base = n_out;
        for (int b = 0; b < 4; b++) drive(1, 8'($urandom), 0);
        chk("lat_k",  64'(bus.m_axis_tvalid), 64'd0);
        drive(0, 8'h00, 0);
        chk("lat_k1", 64'(bus.m_axis_tvalid), 64'd0);
        drive(0, 8'h00, 0);
        chk("lat_k2", 64'(bus.m_axis_tvalid), 64'd1);
        for (int s = 1; s < 24; s++)
            for (int b = 0; b < 4; b++)
                drive(1, 8'($urandom), (s % 8 == 7) && (b == 3));
        drive(0, 8'h00, 0);
        drain();
        chk("t2_count", 64'(n_out - base), 64'd24);

        // 16-bit slots, tlast after first byte of slot 3
        tdm_num = 5'd4; vww = 6'd16;
        for (int b = 0; b < 6; b++) drive(1, 8'($urandom), 0);
        drive(1, 8'($urandom), 1);
        drive(1, 8'($urandom), 0); drive(1, 8'($urandom), 0);
        drive(0, 8'h00, 1);
        drive(0, 8'h00, 0);
        drain();
        chk("t3_rsy", 64'(rsy_cnt), 64'd1);
        chk("t3_rsy_m", 64'(rsy_cnt), 64'(exp_rsy));

        // overflow: tready held low, 12 samples into a depth-8 FIFO
        rdy_mode = 0;
        tdm_num = 5'd16; vww = 6'd8;
        base = n_out;
        for (int i = 0; i < 12; i++) drive(1, 8'($urandom), 0);
        drive(0, 8'h00, 1);
        repeat (5) drive(0, 8'h00, 0);
        while (exp_q.size() > 8) begin
            void'(exp_q.pop_back());
            exp_ovf++;
        end
        chk("t4_ovf", 64'(ovf_cnt), 64'd4);
        chk("t4_ovf_m", 64'(ovf_cnt), 64'(exp_ovf));
        rdy_mode = 1;
        drain();
        chk("t4_count", 64'(n_out - base), 64'd8);

        // random frames with random gaps and 50% tready
        rdy_mode = 2;
        for (int f = 0; f < 14; f++) begin
            tdm_num = 5'($urandom_range(0, 16));
            vww = ($urandom_range(0, 1) != 0) ? 6'd24 : 6'd32;
            n = m_nbytes(); t = m_tdm();
            nb = n * t;
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, nb);
            for (int i = 0; i < nb; i++) begin
                while ($urandom_range(0, 9) < 4) drive(0, 8'h00, 0);
                drive(1, 8'($urandom), i == nb - 1);
            end
        end
        drive(0, 8'h00, 0);
        rdy_mode = 1;
        drain();
        chk("t5_ovf", 64'(ovf_cnt), 64'(exp_ovf));
        chk("t5_rsy", 64'(rsy_cnt), 64'(exp_rsy));

        // reset mid-sample with tvalid pending
        rdy_mode = 0;
        tdm_num = 5'd4; vww = 6'd32;
        for (int i = 0; i < 10; i++) drive(1, 8'($urandom), 0);
        repeat (3) drive(0, 8'h00, 0);
        chk("t6_pending", 64'(bus.m_axis_tvalid), 64'd1);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 8'h5A;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("t6_tdata",  64'(bus.m_axis_tdata),  64'd0);
        chk("t6_tuser",  64'(bus.m_axis_tuser),  64'd0);
        chk("t6_ovf",    64'(ovf_cnt), 64'd0);
        chk("t6_rsy",    64'(rsy_cnt), 64'd0);
        exp_q.delete(); part.delete(); m_slot = 0; exp_ovf = 0; exp_rsy = 0;
        @(negedge bclk);
        bus.s_axis_tvalid = 1'b0;
        repeat (2) @(negedge bclk);
        rst_n = 1'b1;
        repeat (4) @(negedge bclk);
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) drive(1, 8'($urandom), i == 7);
        drive(0, 8'h00, 0);
        drain();
        chk("t6_ovf_end", 64'(ovf_cnt), 64'(exp_ovf));
        chk("t6_rsy_end", 64'(rsy_cnt), 64'(exp_rsy));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
